// File: rtl/dither_pkg.sv
// Shared definitions for the dither scheduler: FSM states, generator constants
// and the amplitude-to-sample mapping.
package dither_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int LFSR_W = 19;
  // x^19 + x^18 + x^17 + x^14 + 1, taps on bits 18, 17, 16 and 13
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 19'h72000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 19'h00001;

  localparam logic [1:0] AMP_MUTE    = 2'd0;
  localparam logic [1:0] AMP_ONE     = 2'd1;
  localparam logic [1:0] AMP_TWO     = 2'd2;
  localparam logic [1:0] AMP_TWO_ALT = 2'd3;

  function automatic logic [2:0] dither_value(input logic [1:0] amp, input logic neg);
    logic [2:0] v;
    case (amp)
      AMP_MUTE:             v = 3'b000;
      AMP_ONE:              v = neg ? 3'b111 : 3'b001;
      AMP_TWO, AMP_TWO_ALT: v = neg ? 3'b110 : 3'b010;
      default:              v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dither_lfsr.sv
// 19-bit maximal-length Fibonacci LFSR; bit_out is the MSB of the current state
// and the register advances by one position on each cycle with step high.
module dither_lfsr
  import dither_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic step,
  output logic bit_out
);

  logic [LFSR_W-1:0] state_q;

  // Shift left, parity of the tapped bits feeds bit 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LFSR_SEED;
    end else if (step) begin
      state_q <= {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
    end else begin
      state_q <= state_q;
    end
  end

  assign bit_out = state_q[LFSR_W-1];

endmodule

// File: rtl/dither_sched.sv
// Dither scheduler: warm-up/run FSM plus a round-robin arbiter that hands out one
// signed dither sample per grant, drawn from the shared LFSR.
module dither_sched
  import dither_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int WARM = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cfg_en,
  input  logic [1:0]     cfg_amp,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic [2:0]     dither,
  output logic           dither_vld,
  output logic           busy
);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [2:0] ptr_q;
  logic [7:0] pend8;
  logic [7:0] gnt8;
  logic [3:0] cand_raw;
  logic [3:0] cand;
  logic [2:0] gnt_idx;
  logic       gnt_hit;
  logic       issue;
  logic       step;
  logic       lfsr_bit;

  // Next-state and warm-up counter
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        wcnt_d = 8'd0;
        if (cfg_en) state_d = ST_WARMUP;
        else        state_d = ST_IDLE;
      end
      ST_WARMUP: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == 8'(WARM - 1)) begin
          state_d = ST_RUN;
          wcnt_d  = 8'd0;
        end else begin
          state_d = ST_WARMUP;
          wcnt_d  = wcnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (!cfg_en) state_d = ST_IDLE;
        else         state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Round-robin search from ptr_q; the channel granted last cycle is masked so a
  // requester that has not yet dropped req cannot be served twice for one request.
  always_comb begin
    pend8          = 8'd0;
    pend8[NCH-1:0] = req & ~grant;
    gnt_hit        = 1'b0;
    gnt_idx        = 3'd0;
    cand_raw       = 4'd0;
    cand           = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      cand_raw = {1'b0, ptr_q} + 4'(i);
      cand     = (cand_raw >= 4'(NCH)) ? (cand_raw - 4'(NCH)) : cand_raw;
      if (!gnt_hit && pend8[cand[2:0]]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand[2:0];
      end else begin
        gnt_hit = gnt_hit;
        gnt_idx = gnt_idx;
      end
    end
    gnt8 = 8'd1 << gnt_idx;
  end

  assign issue = (state_q == ST_RUN) && cfg_en && gnt_hit;
  assign step  = (state_q == ST_WARMUP) || issue;

  dither_lfsr u_lfsr (
    .clk     (clk),
    .rstn    (rstn),
    .step    (step),
    .bit_out (lfsr_bit)
  );

  // State, pointer and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 8'd0;
      ptr_q      <= 3'd0;
      grant      <= '0;
      dither     <= 3'd0;
      dither_vld <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      busy    <= (state_d != ST_IDLE);
      if (issue) begin
        grant      <= gnt8[NCH-1:0];
        dither     <= dither_value(cfg_amp, lfsr_bit);
        dither_vld <= 1'b1;
        ptr_q      <= (gnt_idx == 3'(NCH - 1)) ? 3'd0 : (gnt_idx + 3'd1);
      end else begin
        grant      <= '0;
        dither     <= 3'd0;
        dither_vld <= 1'b0;
        ptr_q      <= ptr_q;
      end
    end
  end

endmodule

// File: doc/dither_sched.md
DITHER_SCHED -- requirements
Module: dither_sched

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels, 2..8.
REQ-002 Parameter WARM, default 32: generator steps in warm-up, 1..255.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 cfg_en  input  1  level; 1 = dither service enabled.
REQ-006 cfg_amp  input  2  amplitude select: 0 mute, 1 = +/-1, 2 = +/-2, 3 = +/-2.
REQ-007 req  input  NCH  per-channel request level; held high until granted.
REQ-008 grant  output  NCH  one-hot grant pulse, registered.
REQ-009 dither  output  3  signed dither sample, valid with grant.
REQ-010 dither_vld  output  1  high in the same cycle as any grant bit.
REQ-011 busy  output  1  high in WARMUP or RUN.

Function
REQ-012 The FSM SHALL have states IDLE, WARMUP and RUN.
REQ-013 IDLE -> WARMUP when cfg_en=1; the warm-up counter loads 0.
REQ-014 In WARMUP the generator SHALL step every cycle; after WARM steps the FSM SHALL enter RUN.
REQ-015 WARMUP or RUN -> IDLE in the cycle after cfg_en is sampled 0; warm-up progress SHALL be discarded.
REQ-016 No grant SHALL be issued in IDLE or WARMUP; requests stay pending.
REQ-017 In RUN the block SHALL arbitrate pending req bits round-robin, at most one grant per cycle.
REQ-018 Round-robin priority: search starts at the channel after the last granted one; after reset, search starts at channel 0.
REQ-019 Latency: req sampled high at edge N -> grant high during cycle N+1; grant SHALL be a single-cycle pulse.
REQ-020 A requester whose req is still high in the cycle of its own grant SHALL NOT be regranted until every other pending channel has been served.
REQ-021 The generator SHALL step exactly once per issued grant in RUN and SHALL hold otherwise.
REQ-022 The generator output bit b SHALL select the sign: b=1 -> negative, b=0 -> positive.
REQ-023 dither SHALL be 0 when cfg_amp=0; +/-1 when cfg_amp=1; +/-2 when cfg_amp is 2 or 3. The result SHALL be in 3-bit two's complement.
REQ-024 cfg_amp SHALL be sampled in the grant-decision cycle; mid-run changes SHALL affect only later samples.
REQ-025 dither SHALL be 0 whenever dither_vld=0.
REQ-026 Simultaneous cfg_en fall and pending requests in RUN: no grant in the following cycle.

Reset
REQ-027 On rstn low: FSM=IDLE, grant=0, dither=0, dither_vld=0, busy=0, the round-robin pointer points to channel 0, the warm-up counter=0, and the generator is loaded with its nonzero seed.
REQ-028 A reset asserted mid-RUN SHALL abort any pending grant immediately (asynchronously); after release the sequence SHALL restart from the seed.

Structure
REQ-029 The shared package dither_pkg SHALL hold: the FSM state enum, the LFSR width (19), the tap mask, the seed (19'h00001), and the amplitude codes.
REQ-030 The generator SHALL be a sub-module dither_lfsr: a 19-bit maximal-length Fibonacci LFSR.
REQ-031 dither_lfsr ports: clk, rstn, step, bit_out.
REQ-032 The arbiter and FSM SHALL reside in dither_sched.

Verification
REQ-033 Reset, cfg_en=1, WARM=32, req=0 -> busy=1 from cycle 1; RUN entered after exactly 32 steps; no grant during warm-up.
REQ-034 NCH=4, req=4'b1111 held in RUN -> grant sequence 0001, 0010, 0100, 1000, 0001, one per cycle, dither_vld high every cycle.
REQ-035 cfg_amp=0 with grants -> dither=0 on every grant; cfg_amp=2 -> every dither value is +2 or -2; the sign stream matches the dither_lfsr reference model from seed 19'h00001.
REQ-036 req=4'b0100 asserted during WARMUP -> first grant=0100 in the cycle after RUN is entered.
REQ-037 cfg_en dropped while req=4'b0011 pending in RUN -> no further grants; busy=0 one cycle later; re-enable repeats the full warm-up.
REQ-038 rstn pulsed low mid-RUN -> all outputs 0 immediately; after release with re-enable, the dither sign sequence restarts identical to the first run.
